// File: rtl/mpmc10_burst_mask_sel.sv
// mpmc10_burst_mask_sel: stages a write burst's byte enables and presents one data mask per beat (0 = write, 1 = masked)
module mpmc10_burst_mask_sel #(
  parameter int WID = 256,
  parameter int BEATS = 4,
  parameter int LW = ($clog2(BEATS) > 0) ? $clog2(BEATS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic                     we,
  input  logic [BEATS*WID/8-1:0]   wmask,
  input  logic [LW-1:0]            len_m1,
  input  logic                     rmw,
  input  logic                     go,
  input  logic                     beat_adv,
  input  logic                     abort,
  output logic [WID/8-1:0]         mask,
  output logic                     mask_vld,
  output logic                     last,
  output logic [LW-1:0]            beat,
  output logic                     busy,
  output logic                     rdy
);
  localparam int MW = WID / 8;
  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;
  state_t state, state_n;
  logic [MW-1:0] stage [BEATS];
  logic [MW-1:0] stage_n [BEATS];
  logic [MW-1:0] mask_n;
  logic [LW-1:0] len, len_n, beat_n, nxt;
  logic vld_n;
  assign nxt = beat + LW'(1);
  assign last = mask_vld && beat == len;
  assign busy = state != IDLE;
  assign rdy = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage <= '{default: '0};
      len <= '0;
      mask <= '1;
      mask_vld <= 1'b0;
      beat <= '0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      len <= len_n;
      mask <= mask_n;
      mask_vld <= vld_n;
      beat <= beat_n;
    end
  end
  // abort outranks every other request; staging survives it
  always_comb begin
    state_n = state;
    stage_n = stage;
    len_n = len;
    mask_n = mask;
    vld_n = mask_vld;
    beat_n = beat;
    if (abort) begin
      state_n = IDLE;
      mask_n = '1;
      vld_n = 1'b0;
      beat_n = '0;
    end else begin
      case (state)
        IDLE: if (ld) begin
          for (int b = 0; b < BEATS; b++)
            stage_n[b] = (we && !rmw) ? ~wmask[b*MW +: MW] : '0;
          len_n = (int'(len_m1) > BEATS - 1) ? LW'(BEATS - 1) : len_m1;
          state_n = HOLD;
        end
        HOLD: begin
          if (rmw) stage_n = '{default: '0};
          if (go) begin
            mask_n = rmw ? '0 : stage[0];
            vld_n = 1'b1;
            beat_n = '0;
            state_n = RUN;
          end
        end
        RUN: if (beat_adv) begin
          if (beat < len) begin
            beat_n = nxt;
            mask_n = stage[nxt];
          end else begin
            mask_n = '1;
            vld_n = 1'b0;
            beat_n = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
